// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: sequencer states and
// operand-forwarding select codes.
package hazard_controller_pkg;

    typedef enum logic {
        HZ_RUN,
        HZ_MC_BUSY
    } hz_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_controller_forwarding_unit.sv
// Combinational operand-forwarding select for the two E-stage sources.
// The M stage result takes priority over W; x0 is never forwarded.
module forwarding_unit
    import hazard_controller_pkg::*;
#(
    parameter int unsigned RA_W = 5
) (
    input  logic [RA_W-1:0] rs1_e,
    input  logic [RA_W-1:0] rs2_e,
    input  logic [RA_W-1:0] rd_m,
    input  logic [RA_W-1:0] rd_w,
    input  logic            reg_write_m,
    input  logic            reg_write_w,
    output logic [1:0]      fwd_a_e,
    output logic [1:0]      fwd_b_e
);

    logic m_valid;
    logic w_valid;

    assign m_valid = reg_write_m & (rd_m != '0);
    assign w_valid = reg_write_w & (rd_w != '0);

    always_comb begin
        fwd_a_e = FWD_RF;
        fwd_b_e = FWD_RF;
        if (m_valid && rd_m == rs1_e)      fwd_a_e = FWD_MEM;
        else if (w_valid && rd_w == rs1_e) fwd_a_e = FWD_WB;
        if (m_valid && rd_m == rs2_e)      fwd_b_e = FWD_MEM;
        else if (w_valid && rd_w == rs2_e) fwd_b_e = FWD_WB;
    end

endmodule

// File: rtl/hazard_controller.sv
// Central stall/flush/forward sequencer for the 5-stage pipeline, with a
// multicycle-execute sequencer and a saturating stall-cycle counter.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int unsigned MC_LATENCY = 4,
    parameter int unsigned RA_W       = 5,
    parameter int unsigned PERF_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RA_W-1:0]   rs1_d,
    input  logic [RA_W-1:0]   rs2_d,
    input  logic [RA_W-1:0]   rs1_e,
    input  logic [RA_W-1:0]   rs2_e,
    input  logic [RA_W-1:0]   rd_e,
    input  logic              load_e,
    input  logic              mc_start_e,
    input  logic [RA_W-1:0]   rd_m,
    input  logic [RA_W-1:0]   rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    input  logic              pc_src_e,
    input  logic              mem_req_m,
    input  logic              dmem_ready,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              flush_w,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              mc_busy,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int unsigned     CNT_W    = $clog2(MC_LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LATENCY - 1);
    localparam bit               MC_MULTI = (MC_LATENCY > 1);
    localparam bit               MC_LONG  = (MC_LATENCY > 2);

    hz_state_t        state, state_next;
    logic [CNT_W-1:0] mc_cnt, mc_cnt_next;
    logic             mem_stall;
    logic             mc_hold;
    logic             load_use;
    logic [1:0]       fwd_a, fwd_b;

    assign mem_stall = mem_req_m & ~dmem_ready;
    assign load_use  = load_e & (rd_e != '0) & ((rd_e == rs1_d) | (rd_e == rs2_d));

    forwarding_unit #(.RA_W(RA_W)) u_fwd (
        .rs1_e       (rs1_e),
        .rs2_e       (rs2_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .fwd_a_e     (fwd_a),
        .fwd_b_e     (fwd_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= HZ_RUN;
            mc_cnt <= '0;
        end else begin
            state  <= state_next;
            mc_cnt <= mc_cnt_next;
        end
    end

    // mc_cnt counts E cycles left including the current one; the start cycle
    // already holds E, so the sequencer leaves MC_BUSY once only the final
    // (advancing) cycle remains. This keeps E occupancy at MC_LATENCY.
    always_comb begin
        state_next  = state;
        mc_cnt_next = mc_cnt;
        mc_hold     = 1'b0;
        unique case (state)
            HZ_RUN: begin
                mc_hold = mc_start_e & MC_MULTI;
                if (mc_start_e && MC_LONG && !mem_stall) begin
                    state_next  = HZ_MC_BUSY;
                    mc_cnt_next = CNT_LOAD;
                end
            end
            HZ_MC_BUSY: begin
                mc_hold = 1'b1;
                if (!mem_stall) begin
                    if (mc_cnt <= CNT_W'(2)) begin
                        state_next  = HZ_RUN;
                        mc_cnt_next = '0;
                    end else begin
                        mc_cnt_next = mc_cnt - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next  = HZ_RUN;
                mc_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        flush_w = 1'b0;
        if (!reset) begin
            if (mem_stall) begin
                {stall_f, stall_d, stall_e, stall_m} = '1;
                flush_w = 1'b1;
            end else if (mc_hold) begin
                {stall_f, stall_d, stall_e} = '1;
                flush_m = 1'b1;
            end else if (pc_src_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    assign fwd_a_e = reset ? FWD_RF : fwd_a;
    assign fwd_b_e = reset ? FWD_RF : fwd_b;
    assign mc_busy = mc_hold & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall_f && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed vector table, multicycle
// corner sequences, and randomized traffic against a behavioural model.
module tb_hazard_controller;

    localparam int unsigned LAT    = 4;
    localparam int unsigned RA_W   = 5;
    localparam int unsigned PERF_W = 4;

    localparam logic [12:0] E_NONE = 13'b0000_0000_00_00_0;
    localparam logic [12:0] E_MEM  = 13'b1111_0001_00_00_0;
    localparam logic [12:0] E_MC   = 13'b1110_0010_00_00_1;
    localparam logic [12:0] E_BR   = 13'b0000_1100_00_00_0;
    localparam logic [12:0] E_LU   = 13'b1100_0100_00_00_0;

    logic clk = 1'b0;
    logic reset;
    logic [RA_W-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic load_e, mc_start_e, reg_write_m, reg_write_w, pc_src_e, mem_req_m, dmem_ready;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic mc_busy;
    logic [PERF_W-1:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_controller #(.MC_LATENCY(LAT), .RA_W(RA_W), .PERF_W(PERF_W)) dut (
        .clk(clk), .reset(reset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .load_e(load_e), .mc_start_e(mc_start_e),
        .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .pc_src_e(pc_src_e), .mem_req_m(mem_req_m), .dmem_ready(dmem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .mc_busy(mc_busy), .stall_cycles(stall_cycles)
    );

    logic [12:0] obs;
    assign obs = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
                  fwd_a_e, fwd_b_e, mc_busy};

    typedef struct packed {
        logic [RA_W-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        logic load, mcs, rwm, rww, pc, req, rdy;
    } in_t;

    typedef struct {
        string       name;
        in_t         in;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic in_t mkin(int a, int b, int c, int d, int e, int m, int w,
                                 bit load, bit mcs, bit rwm, bit rww, bit pc, bit req, bit rdy);
        in_t v;
        v.rs1_d = RA_W'(a); v.rs2_d = RA_W'(b); v.rs1_e = RA_W'(c); v.rs2_e = RA_W'(d);
        v.rd_e = RA_W'(e); v.rd_m = RA_W'(m); v.rd_w = RA_W'(w);
        v.load = load; v.mcs = mcs; v.rwm = rwm; v.rww = rww; v.pc = pc; v.req = req; v.rdy = rdy;
        return v;
    endfunction

    function automatic logic [12:0] fw(logic [1:0] a, logic [1:0] b);
        return {8'b0, a, b, 1'b0};
    endfunction

    task automatic add(string n, in_t i, logic [12:0] e);
        vec_t v;
        v.name = n; v.in = i; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic apply(in_t v);
        rs1_d = v.rs1_d; rs2_d = v.rs2_d; rs1_e = v.rs1_e; rs2_e = v.rs2_e;
        rd_e = v.rd_e; rd_m = v.rd_m; rd_w = v.rd_w;
        load_e = v.load; mc_start_e = v.mcs; reg_write_m = v.rwm; reg_write_w = v.rww;
        pc_src_e = v.pc; mem_req_m = v.req; dmem_ready = v.rdy;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        apply(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Behavioural model state for random traffic
    int  extra_hold;
    bit  start_pending;
    int  stall_total;

    function automatic logic [12:0] model(in_t v, int hold_left);
        logic [12:0] e;
        logic [1:0]  fa, fb;
        bit ms, busy, lu;
        ms   = v.req && !v.rdy;
        busy = (hold_left > 0) || (v.mcs && LAT > 1);
        lu   = v.load && v.rd_e != 0 && (v.rd_e == v.rs1_d || v.rd_e == v.rs2_d);
        fa = 2'b00; fb = 2'b00;
        if (v.rwm && v.rd_m != 0 && v.rd_m == v.rs1_e) fa = 2'b10;
        else if (v.rww && v.rd_w != 0 && v.rd_w == v.rs1_e) fa = 2'b01;
        if (v.rwm && v.rd_m != 0 && v.rd_m == v.rs2_e) fb = 2'b10;
        else if (v.rww && v.rd_w != 0 && v.rd_w == v.rs2_e) fb = 2'b01;
        if (ms)         e = E_MEM;
        else if (busy)  e = 13'b1110_0010_00_00_0;
        else if (v.pc)  e = E_BR;
        else if (lu)    e = E_LU;
        else            e = E_NONE;
        e[0] = busy;
        return e | fw(fa, fb);
    endfunction

    initial begin
        logic [12:0] seq_exp[6];
        in_t v;

        // Reset gating: a stall-worthy input must not show through while reset is high.
        reset = 1'b1;
        apply(mkin(0, 0, 3, 0, 0, 3, 0, 0, 0, 1, 0, 1, 1, 0));
        tick();
        chk("reset_outputs", 32'(obs), 32'(E_NONE));
        chk("reset_perf", 32'(stall_cycles), 0);
        tick();
        reset = 1'b0;

        add("idle",        mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), E_NONE);
        add("fwd_a_mem",   mkin(0, 0, 3, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 1), fw(2'b10, 2'b00));
        add("fwd_b_wb",    mkin(0, 0, 0, 4, 0, 0, 4, 0, 0, 0, 1, 0, 0, 1), fw(2'b00, 2'b01));
        add("fwd_m_over_w",mkin(0, 0, 6, 6, 0, 6, 6, 0, 0, 1, 1, 0, 0, 1), fw(2'b10, 2'b10));
        add("fwd_x0",      mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1), E_NONE);
        add("fwd_m_nowr",  mkin(0, 0, 9, 0, 0, 9, 9, 0, 0, 0, 1, 0, 0, 1), fw(2'b01, 2'b00));
        add("lu_rs1",      mkin(5, 1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 1), E_LU);
        add("lu_rs2",      mkin(1, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0, 1), E_LU);
        add("lu_x0",       mkin(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1), E_NONE);
        add("lu_nomatch",  mkin(6, 7, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 1), E_NONE);
        add("branch",      mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), E_BR);
        add("branch_lu",   mkin(5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 0, 1, 0, 1), E_BR);
        add("mem_stall",   mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), E_MEM);
        add("mem_branch",  mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), E_MEM);
        add("mem_ready",   mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), E_NONE);
        add("mem_fwd",     mkin(0, 0, 2, 0, 0, 2, 0, 0, 0, 1, 0, 0, 1, 0), E_MEM | fw(2'b10, 2'b00));
        add("mem_mc_defer",mkin(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0), E_MEM | 13'd1);
        add("after_defer", mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), E_NONE);

        for (int unsigned i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].in);
            #1;
            chk(tbl[i].name, 32'(obs), 32'(tbl[i].exp));
            tick();
        end

        // Load-use bubble, then the loaded value arrives through W.
        do_reset();
        apply(mkin(5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        #1 chk("seq_lu_stall", 32'(obs), 32'(E_LU));
        tick();
        apply(mkin(0, 0, 5, 0, 0, 0, 5, 0, 0, 0, 1, 0, 0, 1));
        #1 chk("seq_lu_fwd_w", 32'(obs), 32'(fw(2'b01, 2'b00)));
        tick();

        // Multicycle op: three hold cycles, released on the fourth.
        do_reset();
        for (int unsigned c = 0; c < 4; c++) begin
            apply(mkin(0, 0, 0, 0, 0, 0, 0, 0, c == 0, 0, 0, 0, 0, 1));
            #1 chk($sformatf("seq_mc_c%0d", c), 32'(obs), 32'(c < 3 ? E_MC : E_NONE));
            tick();
        end
        chk("seq_mc_perf", 32'(stall_cycles), 3);

        // Memory wait during multicycle op extends E occupancy to six cycles.
        do_reset();
        seq_exp = '{E_MC, E_MC, E_MEM | 13'd1, E_MEM | 13'd1, E_MC, E_NONE};
        for (int unsigned c = 0; c < 6; c++) begin
            apply(mkin(0, 0, 0, 0, 0, 0, 0, 0, c == 0, 0, 0, 0, c >= 2 && c <= 4, !(c == 2 || c == 3)));
            #1 chk($sformatf("seq_mcmem_c%0d", c), 32'(obs), 32'(seq_exp[c]));
            tick();
        end

        // Branch held behind a memory stall is acted on when memory completes.
        do_reset();
        apply(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        #1 chk("seq_br_held", 32'(obs), 32'(E_MEM));
        tick();
        apply(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        #1 chk("seq_br_release", 32'(obs), 32'(E_BR));
        tick();

        // Reset in the middle of a multicycle op.
        do_reset();
        apply(mkin(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        tick();
        apply(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        #1 chk("seq_rst_busy_before", 32'(mc_busy), 1);
        reset = 1'b1;
        #1 chk("seq_rst_outputs", 32'(obs), 32'(E_NONE));
        tick();
        reset = 1'b0;
        #1 chk("seq_rst_after", 32'(obs), 32'(E_NONE));
        chk("seq_rst_perf", 32'(stall_cycles), 0);
        tick();

        // Counter saturation.
        do_reset();
        apply(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int unsigned c = 0; c < 5; c++) tick();
        chk("sat_partial", 32'(stall_cycles), 5);
        for (int unsigned c = 0; c < 20; c++) tick();
        chk("sat_full", 32'(stall_cycles), (1 << PERF_W) - 1);
        tick();
        chk("sat_hold", 32'(stall_cycles), (1 << PERF_W) - 1);

        // Randomized traffic against the behavioural model.
        do_reset();
        extra_hold = 0;
        start_pending = 0;
        stall_total = 0;
        for (int unsigned n = 0; n < 3000; n++) begin
            logic [12:0] e;
            v = mkin($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 2) == 0, 0,
                     $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 5) == 0,
                     $urandom_range(0, 1), $urandom_range(0, 4) > 1);
            v.mcs = start_pending || (extra_hold == 0 && $urandom_range(0, 7) == 0);
            apply(v);
            #1;
            e = model(v, extra_hold);
            chk($sformatf("rand_out_%0d", n), 32'(obs), 32'(e));
            chk($sformatf("rand_perf_%0d", n), 32'(stall_cycles),
                (stall_total > (1 << PERF_W) - 1) ? (1 << PERF_W) - 1 : stall_total);
            if (e[12]) stall_total++;
            if (extra_hold > 0) begin
                if (!(v.req && !v.rdy)) extra_hold--;
            end else if (v.mcs) begin
                if (v.req && !v.rdy) start_pending = 1;
                else begin
                    start_pending = 0;
                    extra_hold = LAT - 2;
                end
            end
            tick();
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                extra_hold = 0;
                start_pending = 0;
                stall_total = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
